// File: rtl/led_chaser.sv
// led_chaser: prescaled LED pattern generator (rotate / bounce / hold).
// Ports: clk, rst_n (async, active-low), en, mode, div, load, load_pat,
//        [bright], gpio, count, shift, dir.
// Optional: define LED_CHASER_PWM_EN to add a 4-bit brightness input and
// a registered PWM mask on gpio (one extra cycle of gpio latency).
module led_chaser #(
    parameter int unsigned      WIDTH    = 8,
    parameter int unsigned      CNT_W    = 27,
    parameter logic [WIDTH-1:0] INIT_PAT = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] div,
    input  logic             load,
    input  logic [WIDTH-1:0] load_pat,
`ifdef LED_CHASER_PWM_EN
    input  logic [3:0]       bright,
`endif
    output logic [WIDTH-1:0] gpio,
    output logic [CNT_W-1:0] count,
    output logic             shift,
    output logic             dir
);

    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_e;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             shift_q, shift_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    dir_e             dir_q, dir_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            shift_q <= 1'b0;
            pat_q   <= INIT_PAT;
            dir_q   <= DIR_UP;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            pat_q   <= pat_d;
            dir_q   <= dir_d;
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        shift_d = 1'b0;
        pat_d   = pat_q;
        dir_d   = dir_q;
        if (load) begin
            // Load wins over a pending step and restarts the prescaler.
            cnt_d = '0;
            pat_d = load_pat;
            dir_d = DIR_UP;
        end else begin
            if (en) begin
                if (cnt_q == div) begin
                    cnt_d   = '0;
                    shift_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            // The registered pulse from the previous cycle applies the step.
            if (shift_q) begin
                case (mode)
                    2'b00: pat_d = {pat_q[WIDTH-2:0], pat_q[WIDTH-1]};
                    2'b01: pat_d = {pat_q[0], pat_q[WIDTH-1:1]};
                    2'b10: begin
                        if (dir_q == DIR_UP && pat_q[WIDTH-1]) begin
                            dir_d = DIR_DN;
                            pat_d = pat_q >> 1;
                        end else if (dir_q == DIR_DN && pat_q[0]) begin
                            dir_d = DIR_UP;
                            pat_d = pat_q << 1;
                        end else if (dir_q == DIR_DN) begin
                            pat_d = pat_q >> 1;
                        end else begin
                            pat_d = pat_q << 1;
                        end
                    end
                    default: pat_d = pat_q;
                endcase
            end
        end
    end

    assign count = cnt_q;
    assign shift = shift_q;
    assign dir   = (dir_q == DIR_DN);

`ifdef LED_CHASER_PWM_EN
    logic [3:0]       pwm_q;
    logic [WIDTH-1:0] gpio_q;

    // Free-running PWM phase; LEDs lit while phase is below brightness.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_q  <= 4'd0;
            gpio_q <= INIT_PAT;
        end else begin
            pwm_q  <= pwm_q + 4'd1;
            gpio_q <= pat_q & {WIDTH{pwm_q < bright}};
        end
    end

    assign gpio = gpio_q;
`else
    assign gpio = pat_q;
`endif

endmodule

// File: tb/tb_led_chaser.sv
// tb_led_chaser: scoreboard bench for led_chaser (default build).
// Random and directed stimulus against an arithmetic reference model.
module tb_led_chaser;
    localparam int W  = 8;
    localparam int CW = 27;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [CW-1:0] div = CW'(3);
    logic          load = 1'b0;
    logic [W-1:0]  load_pat = '0;
    logic [W-1:0]  gpio;
    logic [CW-1:0] count;
    logic          shift;
    logic          dir;

    led_chaser #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .div(div),
        .load(load), .load_pat(load_pat), .gpio(gpio), .count(count),
        .shift(shift), .dir(dir)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pat;
        int cnt;
        int sh;
        int dir;
    } st_t;

    st_t m;
    st_t sb[$];
    st_t e_mon;
    int  n_cmp = 0;
    int  n_bad = 0;

    function automatic void chk(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic st_t rst_state();
        st_t s;
        s.pat = 1; s.cnt = 0; s.sh = 0; s.dir = 0;
        return s;
    endfunction

    // Reference: one clock of behaviour from the rules, in plain arithmetic.
    function automatic st_t next(st_t s, int e_, int md, int ld, int lp, int dv);
        st_t n;
        n = s;
        if (ld != 0) begin
            n.pat = lp; n.cnt = 0; n.sh = 0; n.dir = 0;
            return n;
        end
        n.sh = 0;
        if (e_ != 0) begin
            if (s.cnt == dv) begin n.cnt = 0; n.sh = 1; end
            else n.cnt = s.cnt + 1;
        end
        if (s.sh == 1) begin
            case (md)
                0: n.pat = (s.pat * 2) % 256 + s.pat / 128;
                1: n.pat = s.pat / 2 + (s.pat % 2) * 128;
                2: begin
                    if (s.dir == 0 && s.pat >= 128) begin
                        n.dir = 1; n.pat = s.pat / 2;
                    end else if (s.dir == 1 && (s.pat % 2) == 1) begin
                        n.dir = 0; n.pat = (s.pat * 2) % 256;
                    end else if (s.dir == 1) begin
                        n.pat = s.pat / 2;
                    end else begin
                        n.pat = (s.pat * 2) % 256;
                    end
                end
                default: n.pat = s.pat;
            endcase
        end
        return n;
    endfunction

    // Monitor: every DUT clock result is checked against the queued expectation.
    always begin
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e_mon = sb.pop_front();
            chk("gpio", int'(gpio), e_mon.pat);
            chk("count", int'(count), e_mon.cnt);
            chk("shift", int'(shift), e_mon.sh);
            chk("dir", int'(dir), e_mon.dir);
        end
    end

    task automatic cyc(input bit r, input bit e_, input logic [1:0] md,
                       input bit ld, input logic [7:0] lp, input int dv);
        @(negedge clk);
        rst_n    = r;
        en       = e_;
        mode     = md;
        load     = ld;
        load_pat = lp;
        if (ld) div = CW'(dv);
        if (!r) m = rst_state();
        else m = next(m, int'(e_), int'(md), int'(ld), int'(lp), int'(div));
        sb.push_back(m);
    endtask

    initial begin
        m = rst_state();
        // Held in reset.
        repeat (2) cyc(1'b0, 1'b1, 2'd0, 1'b0, 8'h00, 0);
        // Release with div=3, rotate left.
        repeat (14) cyc(1'b1, 1'b1, 2'd0, 1'b0, 8'h00, 0);
        // Rotate wrap then rotate right.
        cyc(1'b1, 1'b1, 2'd0, 1'b1, 8'h80, 0);
        repeat (4) cyc(1'b1, 1'b1, 2'd0, 1'b0, 8'h00, 0);
        repeat (4) cyc(1'b1, 1'b1, 2'd1, 1'b0, 8'h00, 0);
        // Bounce through both edges.
        cyc(1'b1, 1'b1, 2'd2, 1'b1, 8'h01, 0);
        repeat (20) cyc(1'b1, 1'b1, 2'd2, 1'b0, 8'h00, 0);
        // Load colliding with a step pulse.
        cyc(1'b1, 1'b1, 2'd0, 1'b1, 8'h03, 2);
        for (int i = 0; i < 10; i++) begin
            if (m.sh == 1) break;
            cyc(1'b1, 1'b1, 2'd0, 1'b0, 8'h00, 0);
        end
        chk("collide_setup", m.sh, 1);
        cyc(1'b1, 1'b1, 2'd0, 1'b1, 8'hA5, 2);
        repeat (3) cyc(1'b1, 1'b1, 2'd0, 1'b0, 8'h00, 0);
        // Enable freeze, then hold mode.
        cyc(1'b1, 1'b1, 2'd0, 1'b1, 8'h01, 5);
        repeat (2) cyc(1'b1, 1'b1, 2'd0, 1'b0, 8'h00, 0);
        repeat (10) cyc(1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 0);
        repeat (14) cyc(1'b1, 1'b1, 2'd3, 1'b0, 8'h00, 0);
        // All-zero pattern in each mode.
        cyc(1'b1, 1'b1, 2'd0, 1'b1, 8'h00, 0);
        for (int md = 0; md < 4; md++)
            repeat (3) cyc(1'b1, 1'b1, 2'(md), 1'b0, 8'h00, 0);
        // Async reset between edges with count=2, gpio=0x10.
        cyc(1'b1, 1'b1, 2'd3, 1'b1, 8'h10, 5);
        repeat (2) cyc(1'b1, 1'b1, 2'd3, 1'b0, 8'h00, 0);
        @(posedge clk);
        #3;
        chk("pre_rst_count", int'(count), 2);
        chk("pre_rst_gpio", int'(gpio), 16);
        rst_n = 1'b0;
        #1;
        chk("async_count", int'(count), 0);
        chk("async_gpio", int'(gpio), 1);
        chk("async_dir", int'(dir), 0);
        chk("async_shift", int'(shift), 0);
        cyc(1'b0, 1'b1, 2'd0, 1'b0, 8'h00, 0);
        repeat (10) cyc(1'b1, 1'b1, 2'd0, 1'b0, 8'h00, 0);
        // Randomised run; div only changes alongside load.
        for (int i = 0; i < 500; i++) begin
            logic [7:0] lp;
            lp = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) lp = 8'h00;
            cyc(1'b1, ($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)),
                ($urandom_range(0, 15) == 0), lp, int'($urandom_range(0, 3)));
        end
        @(posedge clk);
        #2;
        chk("queue_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
